nn_result_packer: RTL and testbench
===================================

# nn_result_packer

Downstream stage of `control_unit`: consumes the 1-bit result stream the control unit forwards from the neural net and packs it into WORD_WIDTH-bit words. Each word is written to result BRAM at consecutive addresses starting from a programmed base address. One `start_in` captures one frame of FRAME_BITS result bits, then signals completion with a single-cycle `done_out` pulse.

## Interface
- WORD_WIDTH, 32: bits per RAM word.
- ADDR_WIDTH, 10: RAM address width.
- FRAME_BITS, 256: result bits per frame; need not be a multiple of WORD_WIDTH.
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  begin a frame capture; sampled only in IDLE.
- base_addr_in  input  ADDR_WIDTH  first write address; sampled with `start_in`.
- bit_in  input  1  result bit from control unit.
- bit_valid_in  input  1  `bit_in` valid.
- bit_ready_out  output  1  packer accepts a bit this cycle.
- ram_addr_out  output  ADDR_WIDTH  write address.
- ram_data_out  output  WORD_WIDTH  packed word.
- ram_we_out  output  1  write strobe, one cycle per word.
- busy_out  output  1  high in CAPTURE and FLUSH.
- done_out  output  1  one-cycle pulse on the final word write.
- words_written_out  output  16  words written in the current or last frame.

## Operation
- FSM states: IDLE, CAPTURE, FLUSH.
- IDLE -> CAPTURE when `start_in` is high.
  - Latch `base_addr_in` into the write pointer.
  - Clear the bit counter, shift register and `words_written_out`.
- In CAPTURE, a bit is accepted on any cycle with `bit_valid_in && bit_ready_out`.
  - Bits pack LSB-first: the first accepted bit of a word lands in bit 0.
- When an accepted bit fills a word (WORD_WIDTH bits), the next cycle drives:
  - `ram_we_out`=1, `ram_data_out`=word, `ram_addr_out`=pointer.
  - The pointer then increments and `words_written_out` increments.
  - Capture continues without stall; `bit_ready_out` stays high.
- When the accepted bit is bit number FRAME_BITS of the frame: CAPTURE -> FLUSH.
  - The final word (possibly partial) is written; unfilled upper bits are 0.
- FLUSH lasts exactly one cycle: `ram_we_out`=1, `done_out`=1, `bit_ready_out`=0, then -> IDLE.
- Words per frame = ceil(FRAME_BITS/WORD_WIDTH).
- The write pointer wraps modulo 2^ADDR_WIDTH.
- `start_in` in CAPTURE or FLUSH is ignored.
- `bit_valid_in` in IDLE or FLUSH is not consumed.

## Timing
- All outputs are registered. Reset values:
  - `bit_ready_out`=0, `ram_we_out`=0, `ram_addr_out`=0, `ram_data_out`=0.
  - `busy_out`=0, `done_out`=0, `words_written_out`=0; state IDLE.
- `start_in` at cycle s -> `bit_ready_out`=1 and `busy_out`=1 at s+1.
- A bit completing a word at cycle t -> `ram_we_out` at t+1; latency is one cycle.
- Last bit of frame accepted at t:
  - t+1: FLUSH, with the write and `done_out` pulse.
  - t+2: IDLE, `busy_out`=0; a new `start_in` is honoured from t+2.
- `rst_in` mid-frame: next cycle IDLE with all outputs at reset values; the partial word is discarded and no write is issued.
- `bit_valid_in` gaps of any length change nothing but throughput.

## Configuration
- `NN_RESULT_PACKER_POPCOUNT_EN` defined:
  - Adds output `popcount_out` (width $clog2(FRAME_BITS+1)), the count of 1-bits accepted in the current frame.
  - Cleared on start and on reset; final value is valid from the `done_out` cycle until the next start.
- Undefined: neither the port nor the counter exists. All other behaviour is identical.

## Structure
- `bitnet_pkg` holds:
  - the packer state enum (IDLE/CAPTURE/FLUSH);
  - default WORD_WIDTH/ADDR_WIDTH constants shared with `control_unit` and the RAM wrappers.
- Sub-module `bit_word_packer`:
  - LSB-first shift register with bit index and word-full flag, and a flush-with-zero-pad input.
  - The FSM, address pointer and counters stay in the top module.

## Test plan
- Word packing (WORD_WIDTH=8, FRAME_BITS=16, base 0x10); bits 1,0,1,1,0,0,0,0 then eight 1s:
  - writes 0x0D@0x10 and 0xFF@0x11;
  - single `done_out` pulse coincident with the second write; `words_written_out`=2.
- Partial final word (FRAME_BITS=12, WORD_WIDTH=8); all 1s:
  - writes 0xFF then 0x0F; `done_out` on the 0x0F write.
- Gapped input: same stream as the word-packing test with `bit_valid_in` low every other cycle:
  - identical writes and data, exactly 2 strobes.
- Address wrap (ADDR_WIDTH=4, base 0xF, 2-word frame):
  - writes at 0xF then 0x0.
- Reset after 5 bits accepted:
  - no `ram_we_out`, outputs at reset values;
  - a subsequent start and frame complete normally.
- Start while busy:
  - `start_in` pulsed mid-frame with base 0x20 has no effect on addresses.
  - With `NN_RESULT_PACKER_POPCOUNT_EN`, a 16-bit frame containing 11 ones gives `popcount_out`=11 at `done_out`.

Source files
------------

// File: rtl/bitnet_pkg.sv
// Shared types and default sizes for the result path: packer FSM states and
// the word/address widths used by control_unit and the RAM wrappers.
package bitnet_pkg;

    localparam int DEFAULT_WORD_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_FRAME_BITS = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2
    } packer_state_e;

    // Index width that stays legal for a 1-bit word.
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/nn_result_packer_if.sv
// Bit-stream input, RAM write port and status bundle of nn_result_packer.
// master drives the stream and control, slave is the packer itself.
interface nn_result_packer_if
    import bitnet_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic                  start_in;
    logic [ADDR_WIDTH-1:0] base_addr_in;
    logic                  bit_in;
    logic                  bit_valid_in;
    logic                  bit_ready_out;
    logic [ADDR_WIDTH-1:0] ram_addr_out;
    logic [WORD_WIDTH-1:0] ram_data_out;
    logic                  ram_we_out;
    logic                  busy_out;
    logic                  done_out;
    logic [15:0]           words_written_out;

    modport master (
        output start_in, base_addr_in, bit_in, bit_valid_in,
        input  bit_ready_out, ram_addr_out, ram_data_out, ram_we_out,
               busy_out, done_out, words_written_out
    );

    modport slave (
        input  start_in, base_addr_in, bit_in, bit_valid_in,
        output bit_ready_out, ram_addr_out, ram_data_out, ram_we_out,
               busy_out, done_out, words_written_out
    );

endinterface

// File: rtl/bit_word_packer.sv
// LSB-first word assembler: inserts one bit per shift at the running index and
// flags the shift that completes a word; a flush returns the zero-padded word.
module bit_word_packer
    import bitnet_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clear_i,
    input  logic                  shift_i,
    input  logic                  bit_i,
    input  logic                  flush_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  full_o
);

    localparam int IDX_W = idx_width(WORD_WIDTH);

    logic [WORD_WIDTH-1:0] word_q;
    logic [IDX_W-1:0]      idx_q;

    // Upper bits are still zero from the last clear, so word_o doubles as the padded word.
    always_comb begin
        word_o = word_q;
        if (shift_i) begin
            word_o[idx_q] = bit_i;
        end
    end

    assign full_o = shift_i && (idx_q == IDX_W'(WORD_WIDTH - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_i || full_o || flush_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (shift_i) begin
            word_q <= word_o;
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/nn_result_packer.sv
// Packs the 1-bit result stream into WORD_WIDTH-bit RAM writes, one frame per start.
// Optional NN_RESULT_PACKER_POPCOUNT_EN adds popcount_out (ones accepted this frame).
module nn_result_packer
    import bitnet_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int FRAME_BITS = DEFAULT_FRAME_BITS
) (
    input  logic clk_in,
    input  logic rst_in,
    nn_result_packer_if.slave bus
`ifdef NN_RESULT_PACKER_POPCOUNT_EN
    ,
    output logic [$clog2(FRAME_BITS+1)-1:0] popcount_out
`endif
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    packer_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [15:0]           words_q, words_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  ready_q, ready_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  start_frame;
    logic                  accept;
    logic                  last_bit;
    logic                  word_full;
    logic [WORD_WIDTH-1:0] packed_word;

    assign start_frame = (state_q == IDLE) && bus.start_in;
    assign accept      = (state_q == CAPTURE) && ready_q && bus.bit_valid_in;
    assign last_bit    = accept && (bit_cnt_q == CNT_W'(FRAME_BITS - 1));

    bit_word_packer #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_packer (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear_i(start_frame),
        .shift_i(accept),
        .bit_i  (bus.bit_in),
        .flush_i(last_bit),
        .word_o (packed_word),
        .full_o (word_full)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            words_q   <= '0;
            bit_cnt_q <= '0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            words_q   <= words_d;
            bit_cnt_q <= bit_cnt_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start_in) state_d = CAPTURE;
            CAPTURE: if (last_bit)     state_d = FLUSH;
            FLUSH:                     state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // The final bit of a frame always issues a write, full word or not; that write lands in FLUSH.
    always_comb begin
        ptr_d     = ptr_q;
        words_d   = words_q;
        bit_cnt_d = bit_cnt_q;
        ready_d   = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    ptr_d     = bus.base_addr_in;
                    words_d   = '0;
                    bit_cnt_d = '0;
                    ready_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            CAPTURE: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
                if (accept) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
                if (word_full || last_bit) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = packed_word;
                    ptr_d   = ptr_q + ADDR_WIDTH'(1);
                    words_d = words_q + 16'd1;
                end
                if (last_bit) begin
                    ready_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.bit_ready_out     = ready_q;
    assign bus.ram_we_out        = we_q;
    assign bus.ram_addr_out      = addr_q;
    assign bus.ram_data_out      = data_q;
    assign bus.busy_out          = busy_q;
    assign bus.done_out          = done_q;
    assign bus.words_written_out = words_q;

`ifdef NN_RESULT_PACKER_POPCOUNT_EN
    logic [CNT_W-1:0] pop_q;

    always_ff @(posedge clk_in) begin
        if (rst_in || start_frame) begin
            pop_q <= '0;
        end else if (accept && bus.bit_in) begin
            pop_q <= pop_q + CNT_W'(1);
        end
    end

    assign popcount_out = pop_q;
`endif

endmodule

// File: tb/tb_nn_result_packer.sv
// Bench for nn_result_packer: instance A (W=8, A=8, F=16) and instance B (W=8, A=4, F=12),
// expected RAM writes queued from a bench-side packing model and compared as they appear.
module tb_nn_result_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    nn_result_packer_if #(.WORD_WIDTH(8), .ADDR_WIDTH(8)) ifA ();
    nn_result_packer_if #(.WORD_WIDTH(8), .ADDR_WIDTH(4)) ifB ();

`ifdef NN_RESULT_PACKER_POPCOUNT_EN
    logic [4:0] popA;
    logic [3:0] popB;
`endif

    nn_result_packer #(.WORD_WIDTH(8), .ADDR_WIDTH(8), .FRAME_BITS(16)) dutA (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (ifA)
`ifdef NN_RESULT_PACKER_POPCOUNT_EN
        ,
        .popcount_out(popA)
`endif
    );

    nn_result_packer #(.WORD_WIDTH(8), .ADDR_WIDTH(4), .FRAME_BITS(12)) dutB (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (ifB)
`ifdef NN_RESULT_PACKER_POPCOUNT_EN
        ,
        .popcount_out(popB)
`endif
    );

    typedef struct {
        int addr;
        int data;
        bit last;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];

    int checks = 0;
    int errors = 0;
    int strobes[2];
    int dones[2];
    int expWords[2];
    int expPop[2];
    bit seenDone[2];
    logic [15:0] rnd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setStart(input int w, input logic s, input int base);
        if (w == 0) begin
            ifA.start_in     = s;
            ifA.base_addr_in = 8'(base);
        end else begin
            ifB.start_in     = s;
            ifB.base_addr_in = 4'(base);
        end
    endtask

    task automatic setBit(input int w, input logic v, input logic b);
        if (w == 0) begin
            ifA.bit_valid_in = v;
            ifA.bit_in       = b;
        end else begin
            ifB.bit_valid_in = v;
            ifB.bit_in       = b;
        end
    endtask

    task automatic monitor(input int w);
        logic we, done;
        logic [31:0] addr, data, words;
        int sz;
        exp_t e;
        string p;
`ifdef NN_RESULT_PACKER_POPCOUNT_EN
        logic [31:0] pop;
`endif
        if (w == 0) begin
            p = "A"; we = ifA.ram_we_out; done = ifA.done_out;
            addr = 32'(ifA.ram_addr_out); data = 32'(ifA.ram_data_out);
            words = 32'(ifA.words_written_out); sz = qA.size();
`ifdef NN_RESULT_PACKER_POPCOUNT_EN
            pop = 32'(popA);
`endif
        end else begin
            p = "B"; we = ifB.ram_we_out; done = ifB.done_out;
            addr = 32'(ifB.ram_addr_out); data = 32'(ifB.ram_data_out);
            words = 32'(ifB.words_written_out); sz = qB.size();
`ifdef NN_RESULT_PACKER_POPCOUNT_EN
            pop = 32'(popB);
`endif
        end
        if (done && !we) check({p, "_done_without_we"}, 32'(we), 32'd1);
        if (we) begin
            strobes[w]++;
            if (done) begin
                dones[w]++;
                seenDone[w] = 1'b1;
            end
            if (sz == 0) begin
                check({p, "_unexpected_write"}, 32'(sz), 32'd1);
            end else begin
                if (w == 0) e = qA.pop_front();
                else        e = qB.pop_front();
                check({p, "_addr"}, addr, e.addr);
                check({p, "_data"}, data, e.data);
                check({p, "_done"}, 32'(done), 32'(e.last));
                if (e.last) begin
                    check({p, "_words_written"}, words, expWords[w]);
`ifdef NN_RESULT_PACKER_POPCOUNT_EN
                    check({p, "_popcount"}, pop, expPop[w]);
`endif
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor(0);
        monitor(1);
    endtask

    task automatic checkReset(input int w, input string p);
        if (w == 0) begin
            check({p, "_ready"}, 32'(ifA.bit_ready_out), 32'd0);
            check({p, "_we"},    32'(ifA.ram_we_out), 32'd0);
            check({p, "_addr"},  32'(ifA.ram_addr_out), 32'd0);
            check({p, "_data"},  32'(ifA.ram_data_out), 32'd0);
            check({p, "_busy"},  32'(ifA.busy_out), 32'd0);
            check({p, "_done"},  32'(ifA.done_out), 32'd0);
            check({p, "_words"}, 32'(ifA.words_written_out), 32'd0);
        end else begin
            check({p, "_ready"}, 32'(ifB.bit_ready_out), 32'd0);
            check({p, "_we"},    32'(ifB.ram_we_out), 32'd0);
            check({p, "_busy"},  32'(ifB.busy_out), 32'd0);
            check({p, "_words"}, 32'(ifB.words_written_out), 32'd0);
        end
    endtask

    task automatic readStatus(input int w, output logic r, output logic b);
        if (w == 0) begin r = ifA.bit_ready_out; b = ifA.busy_out; end
        else        begin r = ifB.bit_ready_out; b = ifB.busy_out; end
    endtask

    task automatic driveFrame(input int w, input int base, input int nbits,
                              input logic [15:0] bits, input bit gap, input int startAt);
        int nw, mask, sz;
        exp_t e;
        logic [7:0] d;
        logic r, b;
        nw   = (nbits + 7) / 8;
        mask = (w == 0) ? 255 : 15;
        for (int k = 0; k < nw; k++) begin
            d = '0;
            for (int j = 0; j < 8; j++) begin
                if (k * 8 + j < nbits) d[j] = bits[k * 8 + j];
            end
            e.addr = (base + k) & mask;
            e.data = int'(d);
            e.last = (k == nw - 1);
            if (w == 0) qA.push_back(e);
            else        qB.push_back(e);
        end
        expWords[w] = nw;
        expPop[w]   = 0;
        for (int i = 0; i < nbits; i++) expPop[w] += int'(bits[i]);
        strobes[w]  = 0;
        dones[w]    = 0;
        seenDone[w] = 1'b0;

        setStart(w, 1'b1, base);
        tick();
        setStart(w, 1'b0, 0);
        readStatus(w, r, b);
        check("start_ready", 32'(r), 32'd1);
        check("start_busy",  32'(b), 32'd1);

        for (int i = 0; i < nbits; i++) begin
            if (i == startAt) setStart(w, 1'b1, 32'h20);
            setBit(w, 1'b1, bits[i]);
            tick();
            setStart(w, 1'b0, 0);
            if (gap) begin
                setBit(w, 1'b0, 1'b0);
                tick();
            end
        end
        setBit(w, 1'b0, 1'b0);

        for (int k = 0; k < 8 && !seenDone[w]; k++) tick();
        check("done_seen", 32'(seenDone[w]), 32'd1);
        tick();
        readStatus(w, r, b);
        check("idle_busy",  32'(b), 32'd0);
        check("idle_ready", 32'(r), 32'd0);
        check("strobe_count", strobes[w], nw);
        check("done_pulses", dones[w], 32'd1);
        sz = (w == 0) ? qA.size() : qB.size();
        check("sb_drained", sz, 32'd0);
    endtask

    initial begin
        setStart(0, 1'b0, 0);
        setStart(1, 1'b0, 0);
        setBit(0, 1'b0, 1'b0);
        setBit(1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        checkReset(0, "A_reset");
        checkReset(1, "B_reset");
        rst = 1'b0;
        tick();

        // Word packing, then the same stream with a gap after every bit.
        driveFrame(0, 'h10, 16, 16'hFF0D, 1'b0, -1);
        driveFrame(0, 'h10, 16, 16'hFF0D, 1'b1, -1);

        // Partial final word that also wraps the 4-bit pointer.
        driveFrame(1, 'hF, 12, 16'h0FFF, 1'b0, -1);

        // Start pulsed mid-frame with another base must be ignored; 11 ones in the frame.
        driveFrame(0, 'h30, 16, 16'hF3D6, 1'b0, 5);

        driveFrame(0, 'hFF, 16, 16'h5AA5, 1'b0, -1);

        // Reset after five accepted bits discards the partial word.
        setStart(0, 1'b1, 'h40);
        tick();
        setStart(0, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            setBit(0, 1'b1, 1'b1);
            tick();
        end
        setBit(0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkReset(0, "A_rst_mid");
        tick();
        checkReset(0, "A_after_rst");

        rnd = 16'($urandom);
        driveFrame(0, 'h50, 16, rnd, 1'b0, -1);
        driveFrame(1, 'h5, 12, 16'h0A5C, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
